// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: word/address widths, loader states and the
// default frame sync byte. Also used by the processor side and by frame generators.
package prog_loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    S_SYNC = 4'd0,
    S_AHI  = 4'd1,
    S_ALO  = 4'd2,
    S_CHI  = 4'd3,
    S_CLO  = 4'd4,
    S_DHI  = 4'd5,
    S_DLO  = 4'd6,
    S_CK   = 4'd7,
    S_DONE = 4'd8,
    S_ERR  = 4'd9
  } state_e;

endpackage

// File: rtl/prog_loader_cksum.sv
// 8-bit XOR accumulator over frame bytes, with synchronous clear and enable.
// Only built when PROG_LOADER_CKSUM_EN is defined.
`ifdef PROG_LOADER_CKSUM_EN
module prog_loader_cksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  logic [7:0] acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= 8'h00;
    end else if (clr) begin
      acc_q <= 8'h00;
    end else if (en) begin
      acc_q <= acc_q ^ data;
    end
  end

  assign acc = acc_q;

endmodule
`endif

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses SYNC/ADDR/COUNT/data frames into 16-bit memory writes
// and holds the processor in reset while loading. Checksum byte enabled by PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter bit         START_HELD = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

`ifdef PROG_LOADER_CKSUM_EN
  localparam state_e EndSt = S_CK;
`else
  localparam state_e EndSt = S_DONE;
`endif

  state_e     state_q, state_d;
  addr_t      addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] hi_q, hi_d;
  logic       we_q, we_d;
  addr_t      maddr_q, maddr_d;
  word_t      mdata_q, mdata_d;
  logic       done_q, done_d;
  logic       hold_q, hold_d;
  logic       acc;

  // Nothing stalls the stream; only reset blocks acceptance.
  assign in_ready = reset;
  assign acc      = in_valid && in_ready;

`ifdef PROG_LOADER_CKSUM_EN
  logic       err_q, err_d;
  logic       ck_clr, ck_en;
  logic [7:0] ck_acc;

  prog_loader_cksum u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr   (ck_clr),
    .en    (ck_en),
    .data  (in_data),
    .acc   (ck_acc)
  );
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    done_d  = done_q;
    hold_d  = hold_q;
`ifdef PROG_LOADER_CKSUM_EN
    err_d   = err_q;
    ck_clr  = 1'b0;
    ck_en   = 1'b0;
`endif
    case (state_q)
      S_SYNC, S_DONE, S_ERR: begin
        // done/hold follow S_DONE one cycle late so the last write lands before release.
        if (state_q == S_DONE) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end
        if (acc && in_data == SYNC_BYTE) begin
          state_d = S_AHI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
          err_d   = 1'b0;
          ck_clr  = 1'b1;
`endif
        end
      end
      S_AHI: if (acc) begin
        addr_d[15:8] = in_data;
        state_d      = S_ALO;
      end
      S_ALO: if (acc) begin
        addr_d[7:0] = in_data;
        state_d     = S_CHI;
      end
      S_CHI: if (acc) begin
        cnt_d[15:8] = in_data;
        state_d     = S_CLO;
      end
      S_CLO: if (acc) begin
        cnt_d   = {cnt_q[15:8], in_data};
        state_d = ({cnt_q[15:8], in_data} == 16'd0) ? EndSt : S_DHI;
      end
      S_DHI: if (acc) begin
        hi_d    = in_data;
        state_d = S_DLO;
      end
      S_DLO: if (acc) begin
        we_d    = 1'b1;
        maddr_d = addr_q;
        mdata_d = {hi_q, in_data};
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? EndSt : S_DHI;
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CK: if (acc) begin
        if (in_data == ck_acc) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_SYNC;
    endcase
`ifdef PROG_LOADER_CKSUM_EN
    if (acc && state_q inside {S_AHI, S_ALO, S_CHI, S_CLO, S_DHI, S_DLO}) begin
      ck_en = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_SYNC;
      addr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      hold_q  <= START_HELD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_we   = we_q;
  assign mem_addr = maddr_q;
  assign mem_data = mdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed writes, wrap, zero count,
// checksum failure (when PROG_LOADER_CKSUM_EN is defined) and mid-frame reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int unsigned vec_cnt = 0;
  int unsigned miss_cnt = 0;
  logic [7:0]  ck = 8'h00;

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; drives one byte, checks the write strobe one cycle later.
  task automatic send(input logic [7:0] b, input bit is_lo, input logic [15:0] ea,
                      input logic [15:0] ed);
    in_valid = 1'b1;
    in_data  = b;
    ck       = ck ^ b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mem_we", {31'd0, mem_we}, {31'd0, is_lo});
    if (is_lo) begin
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, ea});
      chk("mem_data", {16'd0, mem_data}, {16'd0, ed});
    end
  endtask

  task automatic send_b(input logic [7:0] b);
    send(b, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic send_hdr(input logic [15:0] a, input logic [15:0] c);
    send_b(8'hA5);
    ck = 8'h00;
    send_b(a[15:8]);
    send_b(a[7:0]);
    send_b(c[15:8]);
    send_b(c[7:0]);
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] ea);
    send(w[15:8], 1'b0, 16'h0, 16'h0);
    send(w[7:0], 1'b1, ea, w);
  endtask

  task automatic send_ck();
`ifdef PROG_LOADER_CKSUM_EN
    send_b(ck);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_we", {31'd0, mem_we}, 32'd0);
    end
  endtask

  task automatic chk_status(input string tag, input bit d, input bit h, input bit e);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_data", {16'd0, mem_data}, 32'd0);
    chk_status("rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready", {31'd0, in_ready}, 32'd1);

    // Basic two-word frame
    send_hdr(16'h0010, 16'h0002);
    chk("f1_hold_mid", {31'd0, cpu_hold}, 32'd1);
    send_word(16'h1234, 16'h0010);
    send_word(16'hABCD, 16'h0011);
    send_ck();
    idle(3);
    chk_status("f1", 1'b1, 1'b0, 1'b0);

    // Leading garbage is discarded
    send_b(8'h00);
    send_b(8'hFF);
    chk("garbage_done", {31'd0, done}, 32'd1);
    send_hdr(16'h0000, 16'h0001);
    send_word(16'hF000, 16'h0000);
    send_ck();
    idle(3);
    chk_status("f2", 1'b1, 1'b0, 1'b0);

    // Address wrap
    send_hdr(16'hFFFF, 16'h0002);
    send_word(16'h1111, 16'hFFFF);
    send_word(16'h2222, 16'h0000);
    send_ck();
    idle(3);
    chk_status("wrap", 1'b1, 1'b0, 1'b0);

    // Zero count, then a new sync re-holds the CPU
    send_hdr(16'h0020, 16'h0000);
    send_ck();
    idle(3);
    chk_status("cnt0", 1'b1, 1'b0, 1'b0);
    send_b(8'hA5);
    chk_status("resync", 1'b0, 1'b1, 1'b0);

`ifdef PROG_LOADER_CKSUM_EN
    // Finish the open frame, then a bad checksum
    ck = 8'h00;
    send_b(8'h00);
    send_b(8'h40);
    send_b(8'h00);
    send_b(8'h00);
    send_ck();
    idle(2);
    send_hdr(16'h0010, 16'h0002);
    send_word(16'h1234, 16'h0010);
    send_word(16'hABCD, 16'h0011);
    chk("ck_expect", {24'd0, ck}, 32'h52);
    send_b(8'h00);
    idle(3);
    chk_status("badck", 1'b0, 1'b1, 1'b1);
    send_hdr(16'h0040, 16'h0001);
    chk("err_clear", {31'd0, err}, 32'd0);
    send_word(16'h0001, 16'h0040);
    send_ck();
    idle(3);
    chk_status("goodck", 1'b1, 1'b0, 1'b0);
    send_b(8'hA5);
`endif

    // Reset after the first data byte of a frame
    send_b(8'h00);
    send_b(8'h30);
    send_b(8'h00);
    send_b(8'h02);
    send_b(8'h55);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk_status("mid_rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    send_b(8'hAA);
    send_b(8'h66);
    idle(3);
    chk_status("post_rst", 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
